// File: rtl/color_gray_pkg.sv
// Shared constants, mode encoding and width helper
// for the streaming RGB-to-grayscale converter.
package color_gray_pkg;

    typedef enum logic [1:0] {
        MODE_SUM  = 2'd0,
        MODE_AVG  = 2'd1,
        MODE_LUMA = 2'd2,
        MODE_MAX  = 2'd3
    } mode_e;

    localparam int COEF_R   = 77;
    localparam int COEF_G   = 150;
    localparam int COEF_B   = 29;
    localparam int COEF_AVG = 85;
    localparam int SHIFT    = 8;

    // Width of products and sums for a given channel width
    function automatic int mid_w(input int dw);
        return dw + 10;
    endfunction

endpackage

// File: rtl/rgb_weighted_sum.sv
// S2/S3 arithmetic datapath: weighted products or max,
// then final sum and shift into the output register.
module rgb_weighted_sum
    import color_gray_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int OUT_W  = DATA_W + 2,
    localparam int MID_W  = mid_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en2,
    input  logic              i_en3,
    input  logic [DATA_W-1:0] i_r,
    input  logic [DATA_W-1:0] i_g,
    input  logic [DATA_W-1:0] i_b,
    input  mode_e             i_mode,
    output logic [OUT_W-1:0]  o_gray
);

    localparam logic [MID_W-1:0] K_R   = MID_W'(COEF_R);
    localparam logic [MID_W-1:0] K_G   = MID_W'(COEF_G);
    localparam logic [MID_W-1:0] K_B   = MID_W'(COEF_B);
    localparam logic [MID_W-1:0] K_AVG = MID_W'(COEF_AVG);

    logic [MID_W-1:0]  w_r;
    logic [MID_W-1:0]  w_g;
    logic [MID_W-1:0]  w_b;
    logic [DATA_W-1:0] w_max;
    logic [MID_W-1:0]  w_pr;
    logic [MID_W-1:0]  w_pg;
    logic [MID_W-1:0]  w_pb;
    logic [MID_W-1:0]  w_sum;
    logic [OUT_W-1:0]  w_res;

    logic [MID_W-1:0]  r_pr;
    logic [MID_W-1:0]  r_pg;
    logic [MID_W-1:0]  r_pb;
    mode_e             r_mode2;
    logic [OUT_W-1:0]  r_gray;

    assign w_r = MID_W'(i_r);
    assign w_g = MID_W'(i_g);
    assign w_b = MID_W'(i_b);

    // Largest of the three channels
    always_comb begin
        w_max = (i_r > i_g) ? i_r : i_g;
        if (i_b > w_max) w_max = i_b;
    end

    // Per-mode weighting of the three channels (MAX uses one lane)
    always_comb begin
        w_pr = '0;
        w_pg = '0;
        w_pb = '0;
        unique case (i_mode)
            MODE_SUM: begin
                w_pr = w_r;
                w_pg = w_g;
                w_pb = w_b;
            end
            MODE_AVG: begin
                w_pr = w_r * K_AVG;
                w_pg = w_g * K_AVG;
                w_pb = w_b * K_AVG;
            end
            MODE_LUMA: begin
                w_pr = w_r * K_R;
                w_pg = w_g * K_G;
                w_pb = w_b * K_B;
            end
            MODE_MAX: begin
                w_pr = MID_W'(w_max);
            end
        endcase
    end

    // S2: hold the weighted terms and the beat's own mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pr    <= '0;
            r_pg    <= '0;
            r_pb    <= '0;
            r_mode2 <= MODE_SUM;
        end else if (i_en2) begin
            r_pr    <= w_pr;
            r_pg    <= w_pg;
            r_pb    <= w_pb;
            r_mode2 <= i_mode;
        end
    end

    // The scaled modes keep the top OUT_W bits, the others the bottom
    assign w_sum = r_pr + r_pg + r_pb;
    assign w_res = (r_mode2 == MODE_AVG || r_mode2 == MODE_LUMA)
                 ? w_sum[SHIFT +: OUT_W]
                 : w_sum[OUT_W-1:0];

    // S3: registered result, frozen while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_gray <= '0;
        else if (i_en3) r_gray <= w_res;
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/rgb_to_gray_stream.sv
// Three-stage valid/ready RGB-to-grayscale pipeline with
// per-frame mode latch and sof/eol sideband.
module rgb_to_gray_stream
    import color_gray_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int OUT_W  = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] R_in,
    input  logic [DATA_W-1:0] G_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic              sof_in,
    input  logic              eol_in,
    input  logic [1:0]        mode_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  grayscale_out,
    output logic              sof_out,
    output logic              eol_out
);

    logic              w_adv1;
    logic              w_adv2;
    logic              w_adv3;
    logic              w_acc;
    mode_e             w_mode;

    mode_e             r_mode;
    logic              r_s1_v;
    logic [DATA_W-1:0] r_s1_r;
    logic [DATA_W-1:0] r_s1_g;
    logic [DATA_W-1:0] r_s1_b;
    logic              r_s1_sof;
    logic              r_s1_eol;
    mode_e             r_s1_mode;
    logic              r_s2_v;
    logic              r_s2_sof;
    logic              r_s2_eol;
    logic              r_s3_v;
    logic              r_s3_sof;
    logic              r_s3_eol;

    assign w_adv3   = !r_s3_v || out_ready;
    assign w_adv2   = !r_s2_v || w_adv3;
    assign w_adv1   = !r_s1_v || w_adv2;
    assign in_ready = w_adv1;
    assign w_acc    = in_valid && w_adv1;

    // An sof beat already runs in the mode it brings
    assign w_mode = sof_in ? mode_e'(mode_in) : r_mode;

    // Frame mode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mode <= MODE_SUM;
        else if (w_acc && sof_in) r_mode <= mode_e'(mode_in);
    end

    // S1: capture pixel, sideband and effective mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_r    <= '0;
            r_s1_g    <= '0;
            r_s1_b    <= '0;
            r_s1_sof  <= 1'b0;
            r_s1_eol  <= 1'b0;
            r_s1_mode <= MODE_SUM;
        end else if (w_adv1) begin
            r_s1_v <= w_acc;
            if (w_acc) begin
                r_s1_r    <= R_in;
                r_s1_g    <= G_in;
                r_s1_b    <= B_in;
                r_s1_sof  <= sof_in;
                r_s1_eol  <= eol_in;
                r_s1_mode <= w_mode;
            end
        end
    end

    // S2 control and sideband
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_s2_sof <= 1'b0;
            r_s2_eol <= 1'b0;
        end else if (w_adv2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_sof <= r_s1_sof;
                r_s2_eol <= r_s1_eol;
            end
        end
    end

    // S3 control and sideband, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_v   <= 1'b0;
            r_s3_sof <= 1'b0;
            r_s3_eol <= 1'b0;
        end else if (w_adv3) begin
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                r_s3_sof <= r_s2_sof;
                r_s3_eol <= r_s2_eol;
            end
        end
    end

    rgb_weighted_sum #(
        .DATA_W (DATA_W)
    ) u_ws (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en2  (w_adv2 && r_s1_v),
        .i_en3  (w_adv3 && r_s2_v),
        .i_r    (r_s1_r),
        .i_g    (r_s1_g),
        .i_b    (r_s1_b),
        .i_mode (r_s1_mode),
        .o_gray (grayscale_out)
    );

    assign out_valid = r_s3_v;
    assign sof_out   = r_s3_sof;
    assign eol_out   = r_s3_eol;

endmodule
